// File: rtl/matrix_mult_nxn_pipelined.sv
// matrix_mult_nxn_pipelined
//   Computes C = A x B for unsigned NxN matrices. A and B are loaded one
//   element per accepted write (row-major, separate wrapping pointers).
//   A start request in IDLE runs N^3 multiply-accumulate issues through a
//   two-stage pipeline (product register, then accumulator). Two drain
//   cycles follow. C is then streamed out row-major over a valid/ready port.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   load_valid : element write strobe
//   load_sel   : 0 selects matrix A, 1 selects matrix B
//   load_data  : element value (DW bits)
//   load_ready : writes are accepted only while high (IDLE)
//   start      : compute request, honoured in IDLE only
//   busy       : high in COMPUTE, DRAIN and OUTPUT
//   res_valid  : res_data holds a valid C element
//   res_ready  : consumer accepts the element when valid & ready
//   res_data   : C element (ACC_W bits), row-major
//   res_last   : marks C[N-1][N-1]
//   done       : one-cycle pulse after the final result handshake
module matrix_mult_nxn_pipelined #(
  parameter int N     = 3,
  parameter int DW    = 8,
  parameter int ACC_W = 2*DW + $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic             load_sel,
  input  logic [DW-1:0]    load_data,
  output logic             load_ready,
  input  logic             start,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             res_last,
  output logic             done
);

  localparam int NN  = N * N;
  localparam int PW  = $clog2(NN);
  localparam int IW  = $clog2(N);
  localparam int PRW = 2 * DW;
  localparam logic [PW-1:0] LAST_P = PW'(NN - 1);
  localparam logic [IW-1:0] LAST_I = IW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DRAIN   = 2'd2,
    S_OUTPUT  = 2'd3
  } state_t;

  // Operand and result storage
  logic [DW-1:0]    r_a [NN];
  logic [DW-1:0]    r_b [NN];
  logic [ACC_W-1:0] r_c [NN];
  logic [PW-1:0]    r_a_ptr;
  logic [PW-1:0]    r_b_ptr;

  // Control state
  state_t           r_state;
  logic [IW-1:0]    r_i;
  logic [IW-1:0]    r_j;
  logic [IW-1:0]    r_k;
  logic             r_drain_cnt;
  logic [PW-1:0]    r_out_idx;

  // Registered outputs
  logic             r_load_ready;
  logic             r_busy;
  logic             r_res_valid;
  logic [ACC_W-1:0] r_res_data;
  logic             r_res_last;
  logic             r_done;

  // Pipeline registers
  logic             r_p1_valid;
  logic             r_p1_first;
  logic             r_p1_last;
  logic [PRW-1:0]   r_p1_prod;
  logic [PW-1:0]    r_p1_cidx;
  logic [ACC_W-1:0] r_acc;

  // Combinational helpers
  logic             w_load_acc;
  logic             w_start_acc;
  logic             w_issue;
  logic [PW-1:0]    w_a_idx;
  logic [PW-1:0]    w_b_idx;
  logic [PW-1:0]    w_c_idx;
  logic [DW-1:0]    w_a_op;
  logic [DW-1:0]    w_b_op;
  logic [PRW-1:0]   w_prod;
  logic [ACC_W-1:0] w_sum;
  logic [PW-1:0]    w_next_out;

  // Handshake qualifiers, operand fetch, multiplier and accumulator adder
  always_comb begin
    w_load_acc  = load_valid & r_load_ready & (r_state == S_IDLE);
    w_start_acc = start & (r_state == S_IDLE);
    w_issue     = (r_state == S_COMPUTE);
    w_a_idx     = PW'(r_i) * PW'(N) + PW'(r_k);
    w_b_idx     = PW'(r_k) * PW'(N) + PW'(r_j);
    w_c_idx     = PW'(r_i) * PW'(N) + PW'(r_j);
    w_a_op      = r_a[w_a_idx];
    w_b_op      = r_b[w_b_idx];
    w_prod      = PRW'(w_a_op) * PRW'(w_b_op);
    // k==0 starts a fresh dot product, so the stale sum is discarded
    if (r_p1_first) begin
      w_sum = ACC_W'(r_p1_prod);
    end else begin
      w_sum = r_acc + ACC_W'(r_p1_prod);
    end
    w_next_out  = r_out_idx + PW'(1);
  end

  // Operand loading: one element per accepted write, pointers wrap at N*N-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_ptr <= '0;
      r_b_ptr <= '0;
      for (int n = 0; n < NN; n++) begin
        r_a[n] <= '0;
        r_b[n] <= '0;
      end
    end else begin
      if (w_load_acc) begin
        if (load_sel) begin
          r_b[r_b_ptr] <= load_data;
          r_b_ptr      <= (r_b_ptr == LAST_P) ? '0 : r_b_ptr + PW'(1);
        end else begin
          r_a[r_a_ptr] <= load_data;
          r_a_ptr      <= (r_a_ptr == LAST_P) ? '0 : r_a_ptr + PW'(1);
        end
      end
      // A start rewinds both pointers; a same-cycle write still lands first
      if (w_start_acc) begin
        r_a_ptr <= '0;
        r_b_ptr <= '0;
      end
    end
  end

  // MAC pipeline: stage 1 registers the product, stage 2 accumulates into C
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p1_valid <= 1'b0;
      r_p1_first <= 1'b0;
      r_p1_last  <= 1'b0;
      r_p1_prod  <= '0;
      r_p1_cidx  <= '0;
      r_acc      <= '0;
      for (int n = 0; n < NN; n++) begin
        r_c[n] <= '0;
      end
    end else begin
      r_p1_valid <= w_issue;
      if (w_issue) begin
        r_p1_prod  <= w_prod;
        r_p1_first <= (r_k == '0);
        r_p1_last  <= (r_k == LAST_I);
        r_p1_cidx  <= w_c_idx;
      end
      if (r_p1_valid) begin
        r_acc <= w_sum;
        if (r_p1_last) begin
          r_c[r_p1_cidx] <= w_sum;
        end
      end
    end
  end

  // Control FSM with registered status and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_i          <= '0;
      r_j          <= '0;
      r_k          <= '0;
      r_drain_cnt  <= 1'b0;
      r_out_idx    <= '0;
      r_load_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_last   <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_COMPUTE;
            r_busy       <= 1'b1;
            r_load_ready <= 1'b0;
            r_i          <= '0;
            r_j          <= '0;
            r_k          <= '0;
          end else begin
            r_load_ready <= 1'b1;
          end
        end
        S_COMPUTE: begin
          // k innermost, then j, then i; the final issue moves to DRAIN
          if (r_k == LAST_I) begin
            r_k <= '0;
            if (r_j == LAST_I) begin
              r_j <= '0;
              if (r_i == LAST_I) begin
                r_i         <= '0;
                r_state     <= S_DRAIN;
                r_drain_cnt <= 1'b0;
              end else begin
                r_i <= r_i + IW'(1);
              end
            end else begin
              r_j <= r_j + IW'(1);
            end
          end else begin
            r_k <= r_k + IW'(1);
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt) begin
            r_state   <= S_OUTPUT;
            r_out_idx <= '0;
          end else begin
            r_drain_cnt <= 1'b1;
          end
        end
        S_OUTPUT: begin
          // First OUTPUT cycle presents C[0]; afterwards advance per handshake
          if (!r_res_valid) begin
            r_res_valid <= 1'b1;
            r_res_data  <= r_c[r_out_idx];
            r_res_last  <= (r_out_idx == LAST_P);
          end else if (res_ready) begin
            if (r_res_last) begin
              r_res_valid  <= 1'b0;
              r_res_last   <= 1'b0;
              r_done       <= 1'b1;
              r_busy       <= 1'b0;
              r_load_ready <= 1'b1;
              r_state      <= S_IDLE;
            end else begin
              r_out_idx  <= w_next_out;
              r_res_data <= r_c[w_next_out];
              r_res_last <= (w_next_out == LAST_P);
            end
          end else begin
            r_res_valid <= r_res_valid;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_busy       <= 1'b0;
          r_res_valid  <= 1'b0;
          r_res_last   <= 1'b0;
          r_load_ready <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready = r_load_ready;
  assign busy       = r_busy;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign res_last   = r_res_last;
  assign done       = r_done;

endmodule

// File: tb/tb_matrix_mult_nxn_pipelined.sv
// tb_matrix_mult_nxn_pipelined
//   Scoreboard bench: every accepted start pushes the full expected C
//   stream (computed with plain nested-loop arithmetic from the bench's own
//   copy of A and B) into a queue; a negedge monitor pops and compares on
//   each result handshake and checks held data under backpressure.
module tb_matrix_mult_nxn_pipelined;

  localparam int N     = 3;
  localparam int DW    = 8;
  localparam int ACC_W = 2*DW + $clog2(N);
  localparam int NN    = N * N;

  logic             clk;
  logic             rst;
  logic             load_valid;
  logic             load_sel;
  logic [DW-1:0]    load_data;
  logic             load_ready;
  logic             start;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic             res_last;
  logic             done;

  matrix_mult_nxn_pipelined #(.N(N), .DW(DW), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_sel   (load_sel),
    .load_data  (load_data),
    .load_ready (load_ready),
    .start      (start),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_last   (res_last),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ACC_W-1:0] data;
    logic             last;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   pop_total = 0;
  int   last_hs_cyc = -10;
  int   m_a[NN];
  int   m_b[NN];
  int   pa = 0;
  int   pb = 0;
  bit   bp_en = 1'b0;
  int   hold_at = -1;
  int   hold_left = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: C[i][j] = sum_k A[i][k]*B[k][j], emitted row-major
  function automatic void push_expected();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        int sum = 0;
        for (int k = 0; k < N; k++) sum += m_a[i*N+k] * m_b[k*N+j];
        e.data = ACC_W'(sum);
        e.last = (i == N-1) && (j == N-1);
        q.push_back(e);
      end
    end
  endfunction

  function automatic void model_clear();
    for (int n = 0; n < NN; n++) begin
      m_a[n] = 0;
      m_b[n] = 0;
    end
    pa = 0;
    pb = 0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare on handshake, check hold under backpressure, done timing
  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got data=%0d, expected no result", res_data);
        end else if (res_ready) begin
          check("res_data", res_data, q[0].data);
          check("res_last", res_last, q[0].last);
          if (res_last) last_hs_cyc = cyc;
          void'(q.pop_front());
          pop_total++;
        end else begin
          check("held_data", res_data, q[0].data);
          check("held_last", res_last, q[0].last);
        end
      end
      if (done) check("done_timing", cyc, last_hs_cyc + 1);
    end
  end

  // Consumer: ready high, random when backpressure is on, forced low for holds
  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_left > 0 && res_valid && pop_total == hold_at) begin
        res_ready = 1'b0;
        hold_left--;
      end else if (bp_en) begin
        res_ready = 1'($urandom_range(0, 1));
      end else begin
        res_ready = 1'b1;
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    q.delete();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_load_ready", load_ready, 1);
  endtask

  task automatic load_elem(input bit sel, input int val, input bit with_start);
    load_valid = 1'b1;
    load_sel   = sel;
    load_data  = DW'(val);
    start      = with_start;
    @(posedge clk);
    if (sel) begin
      m_b[pb] = val;
      pb = (pb + 1) % NN;
    end else begin
      m_a[pa] = val;
      pa = (pa + 1) % NN;
    end
    if (with_start) begin
      pa = 0;
      pb = 0;
      push_expected();
    end
    #1;
    load_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    pa = 0;
    pb = 0;
    push_expected();
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit got = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, got, 1);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_queue_empty"}, q.size(), 0);
    check({tag, "_load_ready"}, load_ready, 1);
    if (!got) apply_reset();
  endtask

  task automatic load_seq(input bit sel, input int base, input int step);
    for (int n = 0; n < NN; n++) load_elem(sel, base + step*n, 1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_sel   = 1'b0;
    load_data  = '0;
    start      = 1'b0;
    @(posedge clk);
    #1;
    check("rst_done", done, 0);
    check("rst_res_last", res_last, 0);
    apply_reset();

    // 1: A=1..9, B=9..1
    load_seq(1'b0, 1, 1);
    load_seq(1'b1, 9, -1);
    do_start();
    wait_done("t1");

    // 2: identity x B, with exact first-valid latency
    for (int n = 0; n < NN; n++) load_elem(1'b0, (n / N == n % N) ? 1 : 0, 1'b0);
    load_seq(1'b1, 1, 1);
    do_start();
    begin
      int cnt = 0;
      for (int c = 0; c < 100; c++) begin
        @(posedge clk);
        #1;
        cnt++;
        if (res_valid) break;
      end
      check("first_valid_latency", cnt, N*N*N + 3);
    end
    wait_done("t2");

    // 3: all 255 under random backpressure
    bp_en = 1'b1;
    load_seq(1'b0, 255, 0);
    load_seq(1'b1, 255, 0);
    do_start();
    wait_done("t3");
    bp_en = 1'b0;

    // 4: ready held low for 5 cycles at element index 4
    load_seq(1'b0, 1, 1);
    load_seq(1'b1, 9, -1);
    hold_at   = pop_total + 4;
    hold_left = 5;
    do_start();
    wait_done("t4");
    check("t4_hold_consumed", hold_left, 0);

    // 5: start mid-COMPUTE and writes during OUTPUT are ignored
    for (int n = 0; n < NN; n++) load_elem(1'b0, $urandom_range(0, 255), 1'b0);
    for (int n = 0; n < NN; n++) load_elem(1'b1, $urandom_range(0, 255), 1'b0);
    do_start();
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < 100 && !res_valid; c++) begin
      @(posedge clk);
      #1;
    end
    for (int c = 0; c < 3; c++) begin
      check("t5_load_ready_output", load_ready, 0);
      load_valid = 1'b1;
      load_sel   = 1'(c);
      load_data  = DW'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      load_valid = 1'b0;
    end
    wait_done("t5a");
    do_start();
    wait_done("t5b");

    // 6: reset mid-COMPUTE, then reload and rerun test 1
    load_seq(1'b0, 1, 1);
    load_seq(1'b1, 9, -1);
    do_start();
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t6_async_busy", busy, 0);
    check("t6_async_valid", res_valid, 0);
    apply_reset();
    repeat (40) @(posedge clk);
    #1;
    check("t6_idle_after_reset", busy, 0);
    load_seq(1'b0, 1, 1);
    load_seq(1'b1, 9, -1);
    do_start();
    wait_done("t6");

    // 7: random matrices, pointer wrap, start on the final write, backpressure
    bp_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < NN + 1; n++) load_elem(1'b0, $urandom_range(0, 255), 1'b0);
      for (int n = 0; n < NN - 1; n++) load_elem(1'b1, $urandom_range(0, 255), 1'b0);
      load_elem(1'b1, $urandom_range(0, 255), 1'b1);
      wait_done("t7");
    end
    bp_en = 1'b0;

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
